// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : irq_controller
//  Purpose  : Interrupt controller for the DMG SoC, on the responder side of
//             the CPU interrupt interface.
//             - Latches rising edges of the peripheral requests into IF
//               (0xFF0F).
//             - Masks IF with IE (0xFFFF).
//             - Presents the pending set to the CPU.
//             - Clears the acknowledged IF bits when the CPU dispatches.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLK           in   1   system clock, rising edge
//    nRES          in   1   synchronous reset, active low
//    A             in  16   CPU address bus
//    D_IN          in   8   CPU write data
//    RD            in   1   read strobe, one cycle wide
//    WR            in   1   write strobe, one cycle wide
//    D_OUT         out  8   registered read data
//    D_OE          out  1   registered read-data valid / drive enable
//    IRQ_SRC       in   5   raw peripheral request levels
//                           (VBlank, STAT, Timer, Serial, Joypad)
//    CPU_IRQ_ACK   in   8   dispatch acknowledge; only [4:0] are used
//    CPU_IRQ_TRIG  out  8   pending & enabled requests; [7:5] are always 0
// ----------------------------------------------------------------------------
//  Configuration macro
//    IRQ_PRIORITY_EN
//      Defined:   CPU_IRQ_TRIG carries only the highest-priority
//                 (lowest-index) pending bit.
//      Undefined: all pending bits are presented.
// ============================================================================
module irq_controller #(
   parameter logic [15:0] IF_ADDR = 16'hFF0F,
   parameter logic [15:0] IE_ADDR = 16'hFFFF,
   parameter int          NUM_SRC = 5
) (
   input  logic               CLK,
   input  logic               nRES,
   input  logic [15:0]        A,
   input  logic [7:0]         D_IN,
   input  logic               RD,
   input  logic               WR,
   output logic [7:0]         D_OUT,
   output logic               D_OE,
   input  logic [NUM_SRC-1:0] IRQ_SRC,
   input  logic [7:0]         CPU_IRQ_ACK,
   output logic [7:0]         CPU_IRQ_TRIG
);

   localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

   logic [NUM_SRC-1:0] if_q;
   logic [7:0]         ie_q;
   logic [NUM_SRC-1:0] src_q;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] if_base;
   logic [NUM_SRC-1:0] if_next;
   logic [NUM_SRC-1:0] pend;
   logic [NUM_SRC-1:0] trig;
   logic               if_sel;
   logic               ie_sel;

   // The upper acknowledge bits have no function.
   logic               unused_ack;
   assign unused_ack = ^CPU_IRQ_ACK[7:NUM_SRC];

   assign if_sel = (A == IF_ADDR);
   assign ie_sel = (A == IE_ADDR);

   always_comb begin
      rise = IRQ_SRC & ~src_q;
      // A CPU write replaces the flags outright, so a same-cycle ack is
      // dropped. A fresh source edge is OR-ed in last so that it can never be
      // lost to either the write or the ack.
      if (WR && if_sel) begin
         if_base = D_IN[NUM_SRC-1:0];
      end else begin
         if_base = if_q & ~CPU_IRQ_ACK[NUM_SRC-1:0];
      end
      if_next = if_base | rise;
   end

   assign pend = if_q & ie_q[NUM_SRC-1:0];

`ifdef IRQ_PRIORITY_EN
   // x & -x isolates the lowest set bit, and bit 0 (VBlank) is the highest
   // priority.
   assign trig = pend & (~pend + ONE);
`else
   logic [NUM_SRC-1:0] unused_one;
   assign unused_one = ONE;
   assign trig       = pend;
`endif

   assign CPU_IRQ_TRIG = {{(8-NUM_SRC){1'b0}}, trig};

   always_ff @(posedge CLK) begin
      // src_q follows the sources even during reset. A level already high
      // when reset is released is therefore not treated as an edge.
      src_q <= IRQ_SRC;
      if (!nRES) begin
         if_q  <= '0;
         ie_q  <= '0;
         D_OUT <= '0;
         D_OE  <= 1'b0;
      end else begin
         if_q <= if_next;
         if (WR && ie_sel) begin
            ie_q <= D_IN;
         end
         // Reads sample the pre-update register values, so a read issued in
         // the same cycle as a write returns the old contents.
         if (RD && if_sel) begin
            D_OUT <= {{(8-NUM_SRC){1'b1}}, if_q};
            D_OE  <= 1'b1;
         end else if (RD && ie_sel) begin
            D_OUT <= ie_q;
            D_OE  <= 1'b1;
         end else begin
            D_OUT <= '0;
            D_OE  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_controller
//  Purpose  : Scoreboard testbench for irq_controller. Directed stimulus
//             pushes the expected results into queues, and a separate monitor
//             compares them against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

   localparam logic [15:0] IF_A = 16'hFF0F;
   localparam logic [15:0] IE_A = 16'hFFFF;
   localparam bit K_TRIG = 1'b0;
   localparam bit K_DOE  = 1'b1;

   logic        clk = 1'b0;
   logic        nres;
   logic [15:0] a;
   logic [7:0]  d_in;
   logic        rd;
   logic        wr;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [4:0]  irq_src;
   logic [7:0]  ack;
   logic [7:0]  trig;

   irq_controller dut (
      .CLK          (clk),
      .nRES         (nres),
      .A            (a),
      .D_IN         (d_in),
      .RD           (rd),
      .WR           (wr),
      .D_OUT        (d_out),
      .D_OE         (d_oe),
      .IRQ_SRC      (irq_src),
      .CPU_IRQ_ACK  (ack),
      .CPU_IRQ_TRIG (trig)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      bit         kind;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t       expq[$];
   logic [7:0] rdq[$];
   string      rdn[$];
   int         cyc    = 0;
   int         checks = 0;
   int         errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Expected TRIG for a given pending set, depending on the build.
   function automatic logic [7:0] exp_trig(input logic [4:0] p);
`ifdef IRQ_PRIORITY_EN
      logic [4:0] lo;
      lo = 5'd0;
      for (int i = 4; i >= 0; i--) begin
         if (p[i]) lo = 5'd1 << i;
      end
      return {3'b000, lo};
`else
      return {3'b000, p};
`endif
   endfunction

   // Monitor: read data is checked whenever D_OE is presented, and
   // cycle-tagged TRIG/D_OE expectations are checked in their cycle.
   always @(negedge clk) begin
      if (d_oe) begin
         checks++;
         if (rdq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: D_OUT=%h with D_OE=1 but no read pending", d_out);
         end else begin
            logic [7:0] e;
            string      n;
            e = rdq.pop_front();
            n = rdn.pop_front();
            if (d_out !== e) begin
               errors++;
               $display("FAIL %s: D_OUT actual=%h expected=%h", n, d_out, e);
            end
         end
      end
      for (int i = expq.size() - 1; i >= 0; i--) begin
         if (expq[i].cyc <= cyc) begin
            checks++;
            if (expq[i].cyc < cyc) begin
               errors++;
               $display("FAIL %s: check missed its cycle %0d (now %0d)", expq[i].name, expq[i].cyc, cyc);
            end else if (expq[i].kind == K_TRIG && trig !== expq[i].val) begin
               errors++;
               $display("FAIL %s: TRIG actual=%h expected=%h", expq[i].name, trig, expq[i].val);
            end else if (expq[i].kind == K_DOE && {7'd0, d_oe} !== expq[i].val) begin
               errors++;
               $display("FAIL %s: D_OE actual=%b expected=%b", expq[i].name, d_oe, expq[i].val[0]);
            end
            expq.delete(i);
         end
      end
   end

   // Inputs change 1 ns after a rising edge; delay d=0 checks the state
   // before the next edge, d=1 checks the state after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int d, input bit k, input logic [7:0] v, input string n);
      exp_t e;
      e.cyc  = cyc + d;
      e.kind = k;
      e.val  = v;
      e.name = n;
      expq.push_back(e);
   endtask

   task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
      a    = addr;
      d_in = data;
      wr   = 1'b1;
      step();
      wr   = 1'b0;
   endtask

   task automatic rd_reg(input logic [15:0] addr, input logic [7:0] e, input string n);
      a  = addr;
      rd = 1'b1;
      rdq.push_back(e);
      rdn.push_back(n);
      step();
      rd = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nres    = 1'b0;
      a       = 16'h0000;
      d_in    = 8'h00;
      rd      = 1'b0;
      wr      = 1'b0;
      irq_src = 5'b00001;
      ack     = 8'h00;
      #1;

      // 1: a source held high through reset must not raise a request.
      step();
      step();
      expect_at(0, K_TRIG, 8'h00, "reset_trig");
      expect_at(0, K_DOE,  8'h00, "reset_doe");
      nres = 1'b1;
      step();
      wr_reg(IE_A, 8'h01);
      expect_at(0, K_TRIG, 8'h00, "no_spurious_edge");
      step();
      expect_at(0, K_TRIG, 8'h00, "no_spurious_edge_2");
      rd_reg(IF_A, 8'hE0, "read_if_after_reset");
      expect_at(1, K_DOE, 8'h00, "doe_drops_after_rd");
      step();

      // 2: an edge sets IF, and an ack clears it while the level stays high.
      wr_reg(IE_A, 8'h1F);
      irq_src = 5'b00000;
      step();
      irq_src = 5'b00100;
      expect_at(1, K_TRIG, exp_trig(5'h04), "edge_to_trig");
      step();
      ack = 8'h04;
      expect_at(1, K_TRIG, 8'h00, "ack_clears");
      step();
      ack = 8'h00;
      step();
      expect_at(0, K_TRIG, 8'h00, "held_level_no_reset");
      rd_reg(IF_A, 8'hE0, "read_if_after_ack");

      // 3: an edge wins over a same-cycle ack on the same bit.
      irq_src = 5'b00110;
      step();
      irq_src = 5'b00100;
      step();
      irq_src = 5'b00110;
      ack     = 8'h02;
      expect_at(1, K_TRIG, exp_trig(5'h02), "edge_beats_ack");
      step();
      ack = 8'h00;
      rd_reg(IF_A, 8'hE2, "read_if_edge_ack");

      // 4: register writes and readback.
      wr_reg(IF_A, 8'hFF);
      expect_at(0, K_TRIG, exp_trig(5'h1F), "if_write_trig");
      rd_reg(IF_A, 8'hFF, "read_if_ff");
      wr_reg(IE_A, 8'h00);
      expect_at(0, K_TRIG, 8'h00, "ie_zero_masks");
      wr_reg(IE_A, 8'hA5);
      expect_at(0, K_TRIG, exp_trig(5'h05), "ie_a5_trig");
      rd_reg(IE_A, 8'hA5, "read_ie_a5");
      // RD and WR together: the write happens, the read returns the old value.
      a    = IE_A;
      d_in = 8'h1F;
      wr   = 1'b1;
      rd   = 1'b1;
      rdq.push_back(8'hA5);
      rdn.push_back("rd_wr_same_cycle");
      step();
      wr = 1'b0;
      rd = 1'b0;

      // 5: all sources pending; priority order when the build enables it.
      expect_at(0, K_TRIG, exp_trig(5'h1F), "all_pending");
      ack = 8'h01;
      expect_at(1, K_TRIG, exp_trig(5'h1E), "after_ack_vblank");
      step();
      ack = 8'h00;
      // A multi-bit ack clears bits 1 and 3; bits [7:5] are ignored.
      ack = 8'hEA;
      expect_at(1, K_TRIG, exp_trig(5'h14), "multi_bit_ack");
      step();
      ack = 8'h00;
      rd_reg(IF_A, 8'hF4, "read_if_multi_ack");

      // 6: a write wins over a same-cycle ack, then reset mid-operation.
      a    = IF_A;
      d_in = 8'h10;
      wr   = 1'b1;
      ack  = 8'h10;
      step();
      wr  = 1'b0;
      ack = 8'h00;
      expect_at(0, K_TRIG, exp_trig(5'h10), "write_beats_ack");
      rd_reg(IF_A, 8'hF0, "read_if_write_ack");
      a    = IF_A;
      rd   = 1'b1;
      nres = 1'b0;
      expect_at(1, K_TRIG, 8'h00, "reset_mid_trig");
      expect_at(1, K_DOE,  8'h00, "reset_mid_doe");
      step();
      rd   = 1'b0;
      nres = 1'b1;
      step();
      wr_reg(IE_A, 8'h1F);
      expect_at(1, K_TRIG, 8'h00, "no_edge_after_reset");
      step();
      step();
      step();

      checks++;
      if (rdq.size() != 0 || expq.size() != 0) begin
         errors++;
         $display("FAIL queues_drained: reads left=%0d checks left=%0d required 0/0", rdq.size(), expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
